// File: rtl/reg_dump_reader.sv
// Walks a register file and streams each word out over a valid/ready port.
// Optional REG_DUMP_SKIP_ZERO_EN starts the walk at index 1.
module reg_dump_reader #(
  parameter int DBITS = 32,
  parameter int ABITS = 4,
  parameter int WORDS = (1 << ABITS)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  output logic [ABITS-1:0] rdInd,
  input  logic [DBITS-1:0] rdData,
  output logic             outValid,
  input  logic             outReady,
  output logic [DBITS-1:0] outData,
  output logic [ABITS-1:0] outIdx,
  output logic             outLast,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ABITS-1:0] LAST_IDX = ABITS'(WORDS - 1);
`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam logic [ABITS-1:0] FIRST_IDX = ABITS'(1);
`else
  localparam logic [ABITS-1:0] FIRST_IDX = '0;
`endif

  state_t           state_q, state_d;
  logic [ABITS-1:0] idx_q, idx_d;
  logic [DBITS-1:0] data_q, data_d;
  logic [ABITS-1:0] oidx_q, oidx_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      // rdData now reflects rdInd sampled at the ISSUE edge
      S_CAPTURE: begin
        data_d  = rdData;
        oidx_d  = idx_q;
        last_d  = (idx_q == LAST_IDX);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (outReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ABITS'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // outputs are registered off the next state
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rdInd    = idx_q;
  assign outValid = valid_q;
  assign outData  = data_q;
  assign outIdx   = oidx_q;
  assign outLast  = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: directed dumps with stalls,
// ignored restarts, mid-dump register writes and mid-dump reset.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rdInd;
  logic [31:0] rdData = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outData;
  logic [3:0]  outIdx;
  logic        outLast;
  logic        busy;
  logic        done;

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NWORDS = 16 - FIRST;

  reg_dump_reader #(.DBITS(32), .ABITS(4), .WORDS(16)) dut (
    .clk(clk), .resetN(resetN), .start(start),
    .rdInd(rdInd), .rdData(rdData),
    .outValid(outValid), .outReady(outReady),
    .outData(outData), .outIdx(outIdx), .outLast(outLast),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [16];
  always @(posedge clk) rdData <= regs[rdInd];

  typedef struct {
    logic [31:0] d;
    logic [3:0]  i;
    logic        l;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetN) begin
      if (outValid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid_idx", {28'h0, outIdx}, 32'hFFFF_FFFF);
        end else begin
          chk("word_data", outData, sbq[0].d);
          chk("word_idx", {28'h0, outIdx}, {28'h0, sbq[0].i});
          chk("word_last", {31'h0, outLast}, {31'h0, sbq[0].l});
          if (outReady) void'(sbq.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_dump(input bit dead5);
    exp_t e;
    for (int i = FIRST; i < 16; i++) begin
      e.d = (dead5 && i == 5) ? 32'hDEAD : 32'h1000 + i;
      e.i = 4'(i);
      e.l = (i == 15);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_word(input int w);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(outValid && outIdx == 4'(w)) && k < 300);
    chk("wait_word_seen", {31'h0, outValid}, 32'h1);
  endtask

  task automatic run_dump(input int exp_cycles);
    int n;
    bit seen;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk("done_seen", {31'h0, seen}, 32'h1);
    if (exp_cycles >= 0) chk("done_cycle", n, exp_cycles);
    @(negedge clk);
    chk("idle_after_done", {31'h0, busy}, 32'h0);
    chk("queue_empty", sbq.size(), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int stall;
    int k;
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;

    #2 resetN = 1'b0;
    #1;
    chk("rst_valid", {31'h0, outValid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rdind", {28'h0, rdInd}, 32'h0);
    chk("rst_data", outData, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_valid", {31'h0, outValid}, 32'h0);

    d0 = done_cnt;
    push_dump(0);
    run_dump(3 * NWORDS);
    #2 chk("done_pulses_basic", done_cnt - d0, 1);
    chk("rdind_cleared", {28'h0, rdInd}, 32'h0);

    d0 = done_cnt;
    push_dump(0);
    fork
      run_dump(-1);
      begin
        wait_word(2);
        @(posedge clk);
        #1 outReady = 1'b0;
        stall = 0;
        k = 0;
        while (stall < 5 && k < 50) begin
          @(negedge clk);
          k++;
          if (outValid && outIdx == 4'd3) stall++;
        end
        @(posedge clk);
        #1 outReady = 1'b1;
        chk("stall_cycles", stall, 5);
      end
    join
    #2 chk("done_pulses_stall", done_cnt - d0, 1);

    d0 = done_cnt;
    push_dump(0);
    fork
      run_dump(3 * NWORDS);
      begin
        wait_word(7);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    chk("restart_ignored_busy", {31'h0, busy}, 32'h0);
    chk("done_pulses_restart", done_cnt - d0, 1);

    push_dump(1);
    fork
      run_dump(3 * NWORDS);
      begin
        wait_word(3);
        regs[5] = 32'hDEAD;
      end
    join
    regs[5] = 32'h1005;

    push_dump(0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_word(9);
    #2 resetN = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, outValid}, 32'h0);
    chk("mid_rst_data", outData, 32'h0);
    chk("mid_rst_idx", {28'h0, outIdx}, 32'h0);
    chk("mid_rst_last", {31'h0, outLast}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_rdind", {28'h0, rdInd}, 32'h0);
    sbq.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_done", done_cnt - d0, 0);

    push_dump(0);
    run_dump(3 * NWORDS);
    #2 chk("done_pulses_after_rst", done_cnt - d0, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter DBITS, default 32, data bits per register word.
REQ-002 Parameter ABITS, default 4, register index bits.
REQ-003 Parameter WORDS, default (1<<ABITS), number of registers walked.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one full dump; sampled only in IDLE.
REQ-007 rdInd  output  ABITS  read index driven to the register file read port.
REQ-008 rdData  input  DBITS  register file read data, valid one posedge after rdInd is presented.
REQ-009 outValid  output  1  outData/outIdx/outLast valid.
REQ-010 outReady  input  1  consumer accepts the word when outValid and outReady are both high at a posedge.
REQ-011 outData  output  DBITS  captured register value.
REQ-012 outIdx  output  ABITS  index of outData.
REQ-013 outLast  output  1  high with outValid on the final word of the dump.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the final handshake.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, CAPTURE, SEND, DONE.
REQ-017 IDLE: start=1 at a posedge SHALL load idx with the first index and go to ISSUE; start=0 SHALL remain in IDLE.
REQ-018 rdInd SHALL equal the idx register in every state.
REQ-019 ISSUE SHALL last exactly one cycle, then go to CAPTURE (register file samples rdInd at this edge).
REQ-020 CAPTURE SHALL last one cycle; at its closing posedge outData<=rdData, outIdx<=idx, outLast<=(idx==WORDS-1); next state SEND.
REQ-021 outValid SHALL be high exactly while in SEND; outData/outIdx/outLast SHALL be stable while outValid=1 and outReady=0.
REQ-022 SEND with outReady=1: if idx==WORDS-1 go to DONE, else idx<=idx+1 and go to ISSUE; with outReady=0 stay in SEND.
REQ-023 DONE SHALL assert done for one cycle, clear idx to 0, and return to IDLE.
REQ-024 Latency: first outValid SHALL rise two cycles after the posedge sampling start; minimum three cycles per word; with outReady tied high a WORDS=16 dump SHALL take 48 cycles plus one DONE cycle.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 idx SHALL never wrap; WORDS-1 is always terminal.
REQ-027 Each word SHALL reflect register contents at its own CAPTURE; the dump is not an atomic snapshot.

Reset
REQ-028 resetN=0 SHALL immediately force IDLE, idx=0, rdInd=0, outValid=0, outData=0, outIdx=0, outLast=0, busy=0, done=0.
REQ-029 Reset asserted mid-dump SHALL abandon the dump; after release no outValid or done SHALL occur until a new start.

Configuration
REQ-030 Macro REG_DUMP_SKIP_ZERO_EN defined: the first index SHALL be 1 and register 0 is never read or sent (WORDS-1 words per dump).
REQ-031 Macro REG_DUMP_SKIP_ZERO_EN undefined: the first index SHALL be 0 and all WORDS words are sent.

Verification
REQ-032 Regfile preloaded reg[i]=0x1000+i, outReady=1, start pulse -> 16 words in order, outIdx 0..15, outData 0x1000..0x100F, outLast only with idx 15, done at cycle 49.
REQ-033 outReady low 5 cycles during word 3 -> outValid, outData=0x1003, and outIdx=3 held stable for all 5 cycles; no word lost or duplicated.
REQ-034 start pulsed again while busy at word 7 -> ignored; exactly 16 words and one done pulse.
REQ-035 resetN low during SEND of word 9 -> all outputs 0 asynchronously; after release, no activity until start; a new start dumps from index 0.
REQ-036 Register 5 written to 0xDEAD before its CAPTURE -> outData for outIdx 5 = 0xDEAD.
REQ-037 REG_DUMP_SKIP_ZERO_EN defined -> first outIdx=1, 15 words, outLast at idx 15, done at cycle 46.
